// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, instr} pairs with synchronous clear, push, pop and occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic [XLEN-1:0] push_instr_i,
  input  logic            pop_i,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_instr_o,
  output logic [CW-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wrap_inc(wr_q);
      if (pop_i)  rd_d = wrap_inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i && !reset_i) begin
      pc_mem_q[wr_q]    <= push_pc_i;
      instr_mem_q[wr_q] <= push_instr_i;
    end
  end

  assign head_pc_o    = pc_mem_q[rd_q];
  assign head_instr_o = instr_mem_q[rd_q];
  assign count_o      = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: one outstanding imem request, responses buffered for decode, PC stalled except on issue.
// Handshakes: imem response counts only when imem_ack && imem_req; decode takes the head when id_valid && id_ready && !flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH = 2,
  parameter int              XLEN  = 32,
  parameter logic [XLEN-1:0] NOP   = XLEN'(NOP_INSTR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            pc_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            issue;
  logic            busy;
  logic            ack_v;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] push_pc;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;
  logic [CW-1:0]   count;

  always_comb begin
    issue     = (state_q == ST_IDLE) && !reset && !flush && (count < DEPTH_C);
    busy      = !reset && (state_q != ST_IDLE);
    imem_req  = issue || busy;
    imem_addr = busy ? req_pc_q : pc_in;
    pc_stall  = !issue;
    ack_v     = imem_ack && imem_req;
    // A response is kept on a same-cycle ack at issue, or in WAIT unless a flush lands with it.
    push      = ack_v && (issue || ((state_q == ST_WAIT) && !flush));
    push_pc   = issue ? pc_in : req_pc_q;
    id_valid  = !reset && (count != '0);
    pop       = id_valid && id_ready && !flush;
    id_pc     = id_valid ? head_pc : '0;
    id_instr  = id_valid ? head_instr : NOP;
  end

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    if (issue) req_pc_d = pc_in;
    case (state_q)
      ST_IDLE: if (issue && !imem_ack) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_ack)   state_d = ST_IDLE;
        else if (flush) state_d = ST_DROP;
      end
      ST_DROP: if (imem_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .CW    (CW)
  ) u_fifo (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (flush),
    .push_i       (push),
    .push_pc_i    (push_pc),
    .push_instr_i (imem_rdata),
    .pop_i        (pop),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .count_o      (count)
  );

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch stage sitting directly downstream of the program counter. It consumes the current word-addressed PC, issues one request at a time to instruction memory over a req/ack handshake, and buffers returned instructions with their PC in a small queue. It presents those instructions to decode with a valid/ready handshake and drives the PC's stall input so the PC advances exactly once per issued fetch.

## Interface
- `DEPTH`, 2: queue entries; must be at least 1.
- `XLEN`, 32: PC and instruction width.
- `NOP`, 32'h00000013: instruction driven on `id_instr` when the queue is empty.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_in`  in  XLEN  current PC (word address) from the PC stage.
- `flush`  in  1  redirect/flush from hazard logic.
- `pc_stall`  out  1  stall to the PC stage; low only in an issue cycle.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  XLEN  request word address.
- `imem_ack`  in  1  response valid; honoured only while `imem_req` is high.
- `imem_rdata`  in  XLEN  instruction returned with `imem_ack`.
- `id_valid`  out  1  head entry valid for decode.
- `id_ready`  in  1  decode accepts the head entry.
- `id_pc`  out  XLEN  PC of the head entry; 0 when the queue is empty.
- `id_instr`  out  XLEN  instruction of the head entry; `NOP` when the queue is empty.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; the response will be kept.
  - DROP: request outstanding; the response will be discarded after a flush.
- Issue condition: `issue = IDLE && !reset && !flush && count < DEPTH`.
- Issue cycle:
  - `imem_req = 1`, `imem_addr = pc_in`.
  - `pc_in` is latched into `req_pc`.
  - `pc_stall = 0`.
- If `imem_ack` arrives in the issue cycle, push {`pc_in`, `imem_rdata`} and stay in IDLE. Otherwise go to WAIT.
- WAIT:
  - `imem_req = 1`, `imem_addr = req_pc` (held stable).
  - On `imem_ack`, push {`req_pc`, `imem_rdata`} and go to IDLE.
  - On `flush` without ack, go to DROP.
  - On `flush` with ack, discard the response and go to IDLE.
- DROP: `imem_req = 1`, `imem_addr = req_pc`. On `imem_ack`, discard the response and go to IDLE.
- `pc_stall = !issue`. It is also high throughout reset.
- Pop occurs when `id_valid && id_ready && !flush`.
- Push and pop in the same cycle leave `count` unchanged.
- `flush` clears the queue (`count = 0`, pointers = 0) the following cycle. It overrides any push or pop in the same cycle.
- Only one request is ever outstanding. A slot is reserved at issue, so a push never meets a full queue.
- Reset:
  - State → IDLE, `count = 0`, pointers = 0, `req_pc = 0`.
  - Outputs: `imem_req = 0`, `imem_addr = pc_in`, `pc_stall = 1`, `id_valid = 0`, `id_pc = 0`, `id_instr = NOP`.
- An `imem_ack` arriving after reset with `imem_req` low is ignored.

## Timing
- Zero-wait memory: an instruction pushed in cycle N is visible on `id_*` in cycle N+1. Sustained throughput is 1 instruction per cycle when `id_ready` is high.
- N wait cycles: `pc_stall` stays high for N cycles after the issue cycle. Decode sees the entry in the cycle after `imem_ack`.
- Queue full (`count == DEPTH`): `imem_req = 0` and `pc_stall = 1` until a pop. An issue may occur in the cycle after the pop.
- Flush in cycle N: `id_valid = 0` from N+1. The next issue is no earlier than N+1 in IDLE, using the redirected `pc_in`.
- `id_*` are driven combinationally from the queue head; no extra register stage.

## Structure
- Shared package `fetch_pkg`: FSM state enum (IDLE/WAIT/DROP) and `NOP_INSTR` constant.
- Sub-module `fetch_fifo`:
  - `DEPTH`-entry circular buffer of {pc, instr}.
  - Synchronous clear, push, pop, `count` output.
  - Pointers wrap modulo `DEPTH`.

## Test plan
- Reset, then ack in every issue cycle with `pc_in` stepping 0x00400000, 0x00400001, … and `id_ready = 1`:
  - `pc_stall` low every cycle.
  - `id_pc` shows 0x00400000, 0x00400001, … one cycle later, each with its `imem_rdata`.
- Same as above but `id_ready = 0`: after 2 pushes, `imem_req = 0` and `pc_stall = 1`. Raise `id_ready` → one pop per cycle, and issue resumes the cycle after the first pop.
- Ack 3 cycles after request at 0x00400004:
  - `imem_addr` holds 0x00400004 and `pc_stall` is high for 3 cycles.
  - `id_valid` rises the cycle after ack with `id_pc = 0x00400004`.
- `flush` during WAIT, ack 2 cycles later: the response is discarded, `id_valid` stays 0, and the next request goes to the new `pc_in` 0x00400040.
- Full queue plus `flush` with `id_ready = 1`: no pop is counted, the queue empties, and `id_instr = 0x00000013`, `id_pc = 0`.
- `reset` asserted in WAIT, ack arrives after reset: the ack is ignored, state is IDLE, and `id_valid = 0`.
